// File: rtl/sram_burst_reader_pkg.sv
// rtl/sram_burst_reader_pkg.sv - shared state encodings, default sizes and credit helper for the SRAM burst reader
package sram_burst_reader_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 8;
  localparam int DEF_N_ENTRIES  = 1024;
  localparam int DEF_BEAT_W     = 8;

  // A new read may go out only if buffered + in-flight beats, less the one leaving now, stays under 2.
  function automatic logic has_credit(input logic [1:0] fifo_count,
                                      input logic       inflight,
                                      input logic       pop);
    return ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/sram_burst_reader_sync_fifo2.sv
// rtl/sram_burst_reader_sync_fifo2.sv - two-entry synchronous FIFO with exposed head and occupancy
module sync_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Storage, pointers and occupancy; the owner never pushes when full nor pops when empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - burst read initiator for the wide-read scratchpad; SRAM_RD_PERF_EN adds a stall counter
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  N_ENTRIES  = DEF_N_ENTRIES,
  parameter int  LANES      = DEF_LANES,
  parameter int  BEAT_W     = DEF_BEAT_W,
  localparam int AW         = $clog2(N_ENTRIES),
  localparam int OW         = DATA_WIDTH * LANES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AW-1:0]     req_base_i,
  input  logic [BEAT_W-1:0] req_beats_i,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [AW-1:0]     sram_addr_o,
  input  logic [OW-1:0]     sram_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OW-1:0]     out_data_o,
  output logic              out_last_o,
  output logic              busy_o
`ifdef SRAM_RD_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [AW-1:0]     addr_q;
  logic [BEAT_W-1:0] issue_cnt_q;
  logic [BEAT_W-1:0] pop_cnt_q;
  logic              inflight_q;
  logic [1:0]        fifo_count;
  logic [OW-1:0]     fifo_head;
  logic              fifo_nonempty;
  logic              accept;
  logic              pop;
  logic              issue;

  assign fifo_nonempty = (fifo_count != 2'd0);
  assign accept        = req_valid_i && (state_q == RD_IDLE);
  assign pop           = fifo_nonempty && out_ready_i;
  assign issue         = (state_q == RD_ISSUE) && (issue_cnt_q != '0) &&
                         has_credit(fifo_count, inflight_q, pop);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: zero-beat requests never leave IDLE; return to IDLE as the last beat leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:  if (accept && (req_beats_i != '0)) state_d = RD_ISSUE;
      RD_ISSUE: if (issue && (issue_cnt_q == BEAT_W'(1))) state_d = RD_DRAIN;
      RD_DRAIN: if (pop && (pop_cnt_q == BEAT_W'(1))) state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  // Outputs decoded from state, credit and FIFO head.
  always_comb begin
    req_ready_o = (state_q == RD_IDLE);
    busy_o      = (state_q != RD_IDLE);
    sram_en_o   = issue;
    sram_we_o   = 1'b0;
    sram_addr_o = addr_q;
    out_valid_o = fifo_nonempty;
    out_data_o  = fifo_head;
    out_last_o  = fifo_nonempty && (pop_cnt_q == BEAT_W'(1));
  end

  // Burst bookkeeping: address walks by LANES and wraps naturally at the SRAM depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= req_base_i;
        issue_cnt_q <= req_beats_i;
        pop_cnt_q   <= req_beats_i;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + AW'(LANES);
          issue_cnt_q <= issue_cnt_q - BEAT_W'(1);
        end
        if (pop) begin
          pop_cnt_q <= pop_cnt_q - BEAT_W'(1);
        end
      end
    end
  end

  sync_fifo2 #(
    .W (OW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (sram_data_i),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

`ifdef SRAM_RD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles a beat waits on downstream; restarts with every request.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      stall_cnt_q <= '0;
    end else if (fifo_nonempty && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb/tb_sram_burst_reader.sv - self-checking bench for sram_burst_reader
module tb_sram_burst_reader;

  localparam int DW = 8;
  localparam int NE = 1024;
  localparam int LN = 8;
  localparam int BW = 8;
  localparam int AW = 10;
  localparam int OW = DW * LN;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_base_i;
  logic [BW-1:0] req_beats_i;
  logic          sram_en_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [OW-1:0] sram_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [OW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
`ifdef SRAM_RD_PERF_EN
  logic [31:0]   stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sram_burst_reader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_base_i  (req_base_i),
    .req_beats_i (req_beats_i),
    .sram_en_o   (sram_en_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_data_i (sram_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
`ifdef SRAM_RD_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM: entry k holds k mod 256; a read returns LN consecutive entries, lane 0 in the low byte.
  logic [DW-1:0] mem [NE];
  initial for (int k = 0; k < NE; k++) mem[k] = DW'(k);
  always @(posedge clk_i) begin
    if (sram_en_o) begin
      for (int i = 0; i < LN; i++) sram_data_i[i*DW +: DW] <= mem[(int'(sram_addr_o) + i) % NE];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [OW-1:0] beat_word(input int base, input int j);
    logic [OW-1:0] w;
    for (int i = 0; i < LN; i++) w[i*DW +: DW] = DW'((base + j * LN + i) % NE);
    return w;
  endfunction

  // Scoreboard: expected addresses and beats are derived from each accepted request.
  logic [OW-1:0] exp_data [$];
  bit            exp_last [$];
  logic [AW-1:0] exp_addr [$];
  logic [AW-1:0] addr_log [$];
  int            addr_cyc [$];
  logic [OW-1:0] pop_data [$];
  bit            pop_last [$];
  int            pop_cyc  [$];
  int            outstanding = 0;
  bit            prev_stall  = 1'b0;
  logic [OW-1:0] prev_data   = '0;
  int            model_stall = 0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      outstanding = 0; prev_stall = 1'b0; model_stall = 0;
    end else begin
      chk("sram_we", 64'(sram_we_o), 64'd0);
      if (sram_en_o) begin
        if (exp_addr.size() == 0) chk("spurious_issue", 64'(sram_addr_o), 64'hFFFF);
        else chk("issue_addr", 64'(sram_addr_o), 64'(exp_addr.pop_front()));
        addr_log.push_back(sram_addr_o);
        addr_cyc.push_back(cyc);
        outstanding++;
      end
      if (outstanding > 3) chk("occupancy", 64'(outstanding), 64'd3);
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid_o), 64'd1);
        chk("stall_data", out_data_o, prev_data);
      end
      if (out_valid_o && !out_ready_i) model_stall++;
      if (out_valid_o && out_ready_i) begin
        if (exp_data.size() == 0) chk("extra_beat", 64'(out_valid_o), 64'd0);
        else begin
          chk("beat_data", out_data_o, exp_data.pop_front());
          chk("beat_last", 64'(out_last_o), 64'(exp_last.pop_front()));
        end
        pop_data.push_back(out_data_o);
        pop_last.push_back(out_last_o);
        pop_cyc.push_back(cyc);
        outstanding--;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      if (req_valid_i && req_ready_o) begin
        model_stall = 0;
        for (int j = 0; j < int'(req_beats_i); j++) begin
          exp_data.push_back(beat_word(int'(req_base_i), j));
          exp_last.push_back(j == int'(req_beats_i) - 1);
          exp_addr.push_back(AW'((int'(req_base_i) + j * LN) % NE));
        end
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete(); addr_cyc.delete();
    pop_data.delete(); pop_last.delete(); pop_cyc.delete();
  endtask

  task automatic start_req(input int base, input int beats);
    bit ok = 1'b0;
    @(posedge clk_i); #1;
    for (int n = 0; n < 100; n++) begin
      if (req_ready_o) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    chk("req_ready_wait", 64'(ok), 64'd1);
    req_valid_i = 1'b1;
    req_base_i  = AW'(base);
    req_beats_i = BW'(beats);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // mode 0: downstream always ready; mode 1: ready pattern 1,0,0 repeating.
  task automatic wait_done(input int mode);
    bit done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (exp_data.size() == 0 && !busy_o) begin done = 1'b1; break; end
      out_ready_i = (mode == 0) ? 1'b1 : (n % 3 == 0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    chk("burst_done", 64'(done), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_en"}, 64'(sram_en_o), 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr_o), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_last"}, 64'(out_last_o), 64'd0);
    chk({tag, "_data"}, out_data_o, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int nlast;
    bit seen;
    rst_i = 1'b1; req_valid_i = 1'b0; req_base_i = '0; req_beats_i = '0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_outputs("reset");

    // Aligned four-beat burst at full rate.
    clear_logs();
    start_req(0, 4);
    wait_done(0);
    chk("t1_n_issue", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", 64'(addr_log[i]), 64'(i * 8));
        chk("t1_addr_cyc", 64'(addr_cyc[i] - addr_cyc[0]), 64'(i));
      end
    end
    chk("t1_n_beats", 64'(pop_data.size()), 64'd4);
    if (pop_data.size() == 4) begin
      chk("t1_beat0", pop_data[0], 64'h0706050403020100);
      chk("t1_beat3", pop_data[3], 64'h1F1E1D1C1B1A1918);
      for (int i = 0; i < 4; i++) begin
        chk("t1_last", 64'(pop_last[i]), 64'(i == 3));
        chk("t1_beat_cyc", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
      end
    end

    // Address wrap at the top of the SRAM.
    clear_logs();
    start_req(1016, 2);
    wait_done(0);
    chk("t2_n_issue", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) begin
      chk("t2_addr0", 64'(addr_log[0]), 64'd1016);
      chk("t2_addr1", 64'(addr_log[1]), 64'd0);
    end
    chk("t2_n_beats", 64'(pop_data.size()), 64'd2);
    if (pop_data.size() == 2) begin
      chk("t2_beat0", pop_data[0], 64'hFFFEFDFCFBFAF9F8);
      chk("t2_beat1", pop_data[1], 64'h0706050403020100);
    end

    // Backpressured six-beat burst from an unaligned base.
    clear_logs();
    start_req(3, 6);
    wait_done(1);
    chk("t3_n_beats", 64'(pop_data.size()), 64'd6);
    if (pop_data.size() == 6) begin
      chk("t3_beat0", pop_data[0], 64'h0A09080706050403);
      chk("t3_beat5", pop_data[5], 64'h3231302F2E2D2C2B);
      nlast = 0;
      for (int i = 0; i < 6; i++) nlast += int'(pop_last[i]);
      chk("t3_n_last", 64'(nlast), 64'd1);
      chk("t3_last5", 64'(pop_last[5]), 64'd1);
    end

    // Zero-beat request is swallowed.
    clear_logs();
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_base_i = AW'(5); req_beats_i = '0;
    @(negedge clk_i);
    chk("t4_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_i);
      chk("t4_en", 64'(sram_en_o), 64'd0);
      chk("t4_valid", 64'(out_valid_o), 64'd0);
      chk("t4_busy", 64'(busy_o), 64'd0);
      chk("t4_req_ready", 64'(req_ready_o), 64'd1);
    end
    chk("t4_n_issue", 64'(addr_log.size()), 64'd0);

    // Reset in the middle of a burst with a read outstanding.
    clear_logs();
    start_req(32, 5);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (pop_data.size() >= 2) begin seen = 1'b1; break; end
    end
    chk("t5_two_beats", 64'(seen), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_outputs("t5_after_reset");
    clear_logs();
    repeat (3) @(negedge clk_i);
    chk("t5_no_stale", 64'(pop_data.size()), 64'd0);
    start_req(200, 3);
    wait_done(0);
    chk("t5_n_beats", 64'(pop_data.size()), 64'd3);
    if (pop_data.size() == 3) begin
      chk("t5_beat0", pop_data[0], 64'hCFCECDCCCBCAC9C8);
      chk("t5_last2", 64'(pop_last[2]), 64'd1);
    end

`ifdef SRAM_RD_PERF_EN
    // Stall counter: five held cycles, then cleared by the next accept.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    start_req(0, 3);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (out_valid_o) begin seen = 1'b1; break; end
    end
    chk("t6_valid_seen", 64'(seen), 64'd1);
    repeat (5) @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    wait_done(0);
    chk("t6_stall_cnt", 64'(stall_cnt_o), 64'd5);
    chk("t6_stall_model", 64'(stall_cnt_o), 64'(model_stall));
    start_req(8, 1);
    @(negedge clk_i);
    chk("t6_stall_clear", 64'(stall_cnt_o), 64'd0);
    wait_done(0);
`endif

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
